// File: rtl/volume_meter_param.sv
`default_nettype none
// ============================================================================
// Module   : volume_meter_param
// Brief    : Windowed peak-to-peak mic volume meter with linear, log2 and
//            decaying peak-hold readings.
// Revision : 1.0 - initial release
// ============================================================================
module volume_meter_param #(
    parameter int SAMPLE_W    = 12,
    parameter int WINDOW_LOG2 = 8,
    parameter int LOWRES_W    = 4,
    parameter int HIRES_W     = 8,
    parameter int LOG_W       = 4,
    parameter int DECAY_LOG2  = 4
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] mic_in,
    output logic [LOWRES_W-1:0] volume_out_lowres,
    output logic [HIRES_W-1:0]  volume_out_hires,
    output logic [LOG_W-1:0]    volume_out_log,
    output logic [HIRES_W-1:0]  peak_hold_hires,
    output logic [SAMPLE_W-1:0] pp_raw,
    output logic                vol_valid
);

    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic [SAMPLE_W-1:0]    max_q, max_d, min_q, min_d;
    logic [SAMPLE_W-1:0]    pp_q, pp_d;
    logic [LOWRES_W-1:0]    lowres_q, lowres_d;
    logic [HIRES_W-1:0]     hires_q, hires_d;
    logic [LOG_W-1:0]       log_q, log_d;
    logic [HIRES_W-1:0]     peak_q, peak_d;
    logic [DECAY_LOG2:0]    decay_q, decay_d;
    logic                   valid_q, valid_d;

    logic [SAMPLE_W-1:0]    w_max_new, w_min_new, w_pp_new;
    logic [HIRES_W-1:0]     w_hires_new, w_peak_dec;

    // Bit-length of (pp-1); pp=0 maps to 0 rather than the wrapped all-ones length.
    function automatic logic [LOG_W-1:0] f_log(input logic [SAMPLE_W-1:0] pp);
        logic [SAMPLE_W-1:0] m;
        f_log = '0;
        m     = pp - SAMPLE_W'(1);
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (m[i]) f_log = LOG_W'(i + 1);
        end
        if (pp == '0) f_log = '0;
    endfunction

    always_comb begin
        w_max_new   = (first_q || mic_in > max_q) ? mic_in : max_q;
        w_min_new   = (first_q || mic_in < min_q) ? mic_in : min_q;
        w_pp_new    = w_max_new - w_min_new;
        w_hires_new = w_pp_new[SAMPLE_W-1 -: HIRES_W];
        w_peak_dec  = peak_q - HIRES_W'(1);

        cnt_d    = cnt_q;
        first_d  = first_q;
        max_d    = max_q;
        min_d    = min_q;
        pp_d     = pp_q;
        lowres_d = lowres_q;
        hires_d  = hires_q;
        log_d    = log_q;
        peak_d   = peak_q;
        decay_d  = decay_q;
        valid_d  = 1'b0;

        if (clear) begin
            cnt_d   = '0;
            first_d = 1'b1;
            decay_d = '0;
            peak_d  = '0;
        end else if (sample_en) begin
            max_d   = w_max_new;
            min_d   = w_min_new;
            first_d = 1'b0;
            cnt_d   = cnt_q + WINDOW_LOG2'(1);
            if (&cnt_q) begin
                pp_d     = w_pp_new;
                lowres_d = w_pp_new[SAMPLE_W-1 -: LOWRES_W];
                hires_d  = w_hires_new;
                log_d    = f_log(w_pp_new);
                valid_d  = 1'b1;
                first_d  = 1'b1;
                if (w_hires_new >= peak_q) begin
                    peak_d  = w_hires_new;
                    decay_d = '0;
                end else if (!decay_q[DECAY_LOG2]) begin
                    // Top bit set means the dwell count has reached 2^DECAY_LOG2.
                    decay_d = decay_q + (DECAY_LOG2+1)'(1);
                end else begin
                    peak_d = (w_peak_dec > w_hires_new) ? w_peak_dec : w_hires_new;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            first_q  <= 1'b1;
            max_q    <= '0;
            min_q    <= '0;
            pp_q     <= '0;
            lowres_q <= '0;
            hires_q  <= '0;
            log_q    <= '0;
            peak_q   <= '0;
            decay_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            max_q    <= max_d;
            min_q    <= min_d;
            pp_q     <= pp_d;
            lowres_q <= lowres_d;
            hires_q  <= hires_d;
            log_q    <= log_d;
            peak_q   <= peak_d;
            decay_q  <= decay_d;
            valid_q  <= valid_d;
        end
    end

    assign volume_out_lowres = lowres_q;
    assign volume_out_hires  = hires_q;
    assign volume_out_log    = log_q;
    assign peak_hold_hires   = peak_q;
    assign pp_raw            = pp_q;
    assign vol_valid         = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_volume_meter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_volume_meter_param
// Brief    : Directed self-checking bench for volume_meter_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_volume_meter_param;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        sample_en;
    logic [11:0] mic_in;
    logic [3:0]  volume_out_lowres;
    logic [7:0]  volume_out_hires;
    logic [3:0]  volume_out_log;
    logic [7:0]  peak_hold_hires;
    logic [11:0] pp_raw;
    logic        vol_valid;

    int n_total = 0;
    int n_bad   = 0;

    volume_meter_param dut (
        .clk_in            (clk_in),
        .rst_n             (rst_n),
        .clear             (clear),
        .sample_en         (sample_en),
        .mic_in            (mic_in),
        .volume_out_lowres (volume_out_lowres),
        .volume_out_hires  (volume_out_hires),
        .volume_out_log    (volume_out_log),
        .peak_hold_hires   (peak_hold_hires),
        .pp_raw            (pp_raw),
        .vol_valid         (vol_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; return 1 ns after the capturing edge.
    task automatic step(input logic en, input logic [11:0] v);
        sample_en = en;
        mic_in    = v;
        @(posedge clk_in);
        #1;
    endtask

    // mode 0: alternate a/b; 1: a then b as 256th; 2: a+(i%17); 3: a first then b
    task automatic win(input string tag, input int mode, input logic [11:0] a,
                       input logic [11:0] b, input int n);
        int early = 0;
        logic [11:0] v;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       v = (i % 2 == 1) ? b : a;
                1:       v = (i == 255) ? b : a;
                2:       v = a + 12'(i % 17);
                default: v = (i == 0) ? a : b;
            endcase
            step(1'b1, v);
            if (i < 255 && vol_valid) early++;
        end
        chk({tag, "_early"}, early, 0);
    endtask

    task automatic chk_out(input string tag, input logic [11:0] pp, input logic [3:0] lo,
                           input logic [7:0] hi, input logic [3:0] lg);
        chk({tag, "_valid"}, vol_valid, 1);
        chk({tag, "_pp"}, pp_raw, pp);
        chk({tag, "_lo"}, volume_out_lowres, lo);
        chk({tag, "_hi"}, volume_out_hires, hi);
        chk({tag, "_log"}, volume_out_log, lg);
    endtask

    initial begin
        int early;
        rst_n = 1'b0; clear = 1'b0;
        step(1'b1, 12'hABC);
        step(1'b1, 12'h123);
        chk("rst_pp", pp_raw, 0);
        chk("rst_lo", volume_out_lowres, 0);
        chk("rst_hi", volume_out_hires, 0);
        chk("rst_log", volume_out_log, 0);
        chk("rst_peak", peak_hold_hires, 0);
        chk("rst_valid", vol_valid, 0);
        rst_n = 1'b1;

        win("alt", 0, 12'h100, 12'h900, 256);
        chk_out("alt", 12'h800, 4'd8, 8'h80, 4'd11);
        chk("alt_peak", peak_hold_hires, 8'h80);
        step(1'b0, 12'h000);
        chk("alt_pulse", vol_valid, 0);
        chk("alt_hold", pp_raw, 12'h800);

        win("full", 0, 12'h000, 12'hFFF, 256);
        chk_out("full", 12'hFFF, 4'd15, 8'hFF, 4'd12);
        win("flat", 0, 12'h7FF, 12'h7FF, 256);
        chk_out("flat", 12'h000, 4'd0, 8'h00, 4'd0);
        win("pp1", 0, 12'h7FF, 12'h800, 256);
        chk_out("pp1", 12'h001, 4'd0, 8'h00, 4'd0);
        win("pp2", 0, 12'h7FF, 12'h801, 256);
        chk_out("pp2", 12'h002, 4'd0, 8'h00, 4'd1);
        win("pp801", 0, 12'h000, 12'h801, 256);
        chk_out("pp801", 12'h801, 4'd8, 8'h80, 4'd12);

        early = 0;
        for (int k = 0; k < 256; k++) begin
            step(1'b0, 12'hFFF);
            if (vol_valid) early++;
            step(1'b0, 12'hFFF);
            if (vol_valid) early++;
            step(1'b1, 12'h400 + 12'(k));
            if (k < 255 && vol_valid) early++;
        end
        chk("qual_early", early, 0);
        chk_out("qual", 12'h0FF, 4'd0, 8'h0F, 4'd8);

        clear = 1'b1;
        step(1'b0, 12'h000);
        clear = 1'b0;
        chk("clr_peak", peak_hold_hires, 0);
        win("dec0", 0, 12'h100, 12'h900, 256);
        chk("dec0_peak", peak_hold_hires, 8'h80);
        for (int w = 1; w <= 18; w++) begin
            win("decw", 0, 12'h7FF, 12'h7FF, 256);
            if (w <= 16) chk("dec_hold", peak_hold_hires, 8'h80);
            else         chk("dec_fall", peak_hold_hires, 8'h80 - 8'(w - 16));
        end

        win("loud", 0, 12'h000, 12'hFFF, 100);
        rst_n = 1'b0;
        step(1'b1, 12'hFFF);
        rst_n = 1'b1;
        chk("mrst_pp", pp_raw, 0);
        chk("mrst_peak", peak_hold_hires, 0);
        win("quiet", 2, 12'h200, 12'h000, 256);
        chk_out("quiet", 12'h010, 4'd0, 8'h01, 4'd4);
        chk("quiet_peak", peak_hold_hires, 8'h01);

        win("part", 0, 12'h000, 12'hFFF, 50);
        clear = 1'b1;
        step(1'b1, 12'hFFF);
        clear = 1'b0;
        chk("mclr_peak", peak_hold_hires, 0);
        chk("mclr_pp", pp_raw, 12'h010);
        chk("mclr_hi", volume_out_hires, 8'h01);
        chk("mclr_valid", vol_valid, 0);
        win("postclr", 0, 12'h500, 12'h510, 256);
        chk_out("postclr", 12'h010, 4'd0, 8'h01, 4'd4);

        win("last", 1, 12'h800, 12'h000, 256);
        chk_out("last", 12'h800, 4'd8, 8'h80, 4'd11);
        win("b2b", 3, 12'h300, 12'h308, 256);
        chk_out("b2b", 12'h008, 4'd0, 8'h00, 4'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
